// File: rtl/hex_word_tx_pkg.sv
// Shared types and constants for the hex word transmitter: frame states,
// ASCII byte values and line-ending encodings.
package hex_word_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PFX0   = 3'd1,
    PFX1   = 3'd2,
    DIGIT  = 3'd3,
    EOL_CR = 3'd4,
    EOL_LF = 3'd5
  } state_e;

  localparam logic [7:0] ASC_ZERO    = 8'h30;
  localparam logic [7:0] ASC_X       = 8'h78;
  localparam logic [7:0] ASC_CR      = 8'h0D;
  localparam logic [7:0] ASC_LF      = 8'h0A;
  localparam logic [7:0] ASC_UPPER_A = 8'h41;
  localparam logic [7:0] ASC_LOWER_A = 8'h61;

  localparam logic [1:0] EOL_ENC_NONE = 2'd0;
  localparam logic [1:0] EOL_ENC_LF   = 2'd1;
  localparam logic [1:0] EOL_ENC_CRLF = 2'd2;

endpackage

// File: rtl/hex_word_tx_if.sv
// Request and UART byte-port bundle for hex_word_tx.
// HEX_WORD_TX_ZSUPPRESS_EN adds the i_zsup request qualifier.
interface hex_word_tx_if #(
  parameter int DW = 32
);

  logic          i_stb;
  logic [DW-1:0] i_data;
  logic          i_lower;
`ifdef HEX_WORD_TX_ZSUPPRESS_EN
  logic          i_zsup;
`endif
  logic          o_busy;
  logic          o_tx_stb;
  logic [7:0]    o_tx_data;
  logic          i_tx_busy;

`ifdef HEX_WORD_TX_ZSUPPRESS_EN
  modport master (
    output i_stb, i_data, i_lower, i_zsup, i_tx_busy,
    input  o_busy, o_tx_stb, o_tx_data
  );
  modport slave (
    input  i_stb, i_data, i_lower, i_zsup, i_tx_busy,
    output o_busy, o_tx_stb, o_tx_data
  );
`else
  modport master (
    output i_stb, i_data, i_lower, i_tx_busy,
    input  o_busy, o_tx_stb, o_tx_data
  );
  modport slave (
    input  i_stb, i_data, i_lower, i_tx_busy,
    output o_busy, o_tx_stb, o_tx_data
  );
`endif

endinterface

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit nibble to ASCII hex digit, with selectable letter case.
module hex_nibble_ascii
  import hex_word_tx_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_lower,
  output logic [7:0] o_ascii
);

  // Digits map from '0', letters from 'A' or 'a' offset by ten
  always_comb begin
    o_ascii = ASC_ZERO;
    if (i_nib < 4'd10) begin
      o_ascii = ASC_ZERO + {4'h0, i_nib};
    end else if (i_lower) begin
      o_ascii = ASC_LOWER_A + {4'h0, i_nib} - 8'd10;
    end else begin
      o_ascii = ASC_UPPER_A + {4'h0, i_nib} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_word_tx.sv
// Prints one DW-bit word per request as ASCII hex onto a strobe/busy byte port.
// Optional HEX_WORD_TX_ZSUPPRESS_EN: leading-zero suppression via i_zsup.
module hex_word_tx
  import hex_word_tx_pkg::*;
#(
  parameter int         DW         = 32,
  parameter bit         ADD_PREFIX = 1'b1,
  parameter logic [1:0] EOL        = EOL_ENC_CRLF
) (
  input logic         i_clk,
  input logic         i_reset,
  hex_word_tx_if.slave io_bus
);

  localparam int NIB = DW / 32'sd4;
  localparam int CW  = (NIB > 32'sd1) ? $clog2(NIB) : 32'sd1;
  localparam logic [CW-1:0] CNT_TOP = CW'(NIB - 32'sd1);

  localparam state_e FIRST_ST = ADD_PREFIX ? PFX0 : DIGIT;
  localparam state_e TAIL_ST  = (EOL == EOL_ENC_CRLF) ? EOL_CR :
                                (EOL == EOL_ENC_LF)   ? EOL_LF : IDLE;

  if ((DW % 32'sd4 != 32'sd0) || (DW < 32'sd4) || (DW > 32'sd64)) begin : g_dw_check
    $error("hex_word_tx: DW must be a multiple of 4 in the range 4..64");
  end

  state_e        r_state;
  logic [DW-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic          r_lower;
  logic          r_tx_stb;
  logic [7:0]    r_tx_data;

  state_e        w_state_nx;
  logic [DW-1:0] w_shift_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_lower_nx;
  logic [DW-1:0] w_load;
  logic [CW-1:0] w_cnt_load;
  logic [7:0]    w_digit_nx;
  logic [7:0]    w_byte_nx;
  logic          w_busy;
  logic          w_accept;
  logic          w_xfer;

  assign w_busy   = (r_state != IDLE) | io_bus.i_tx_busy;
  assign w_accept = io_bus.i_stb & ~w_busy;
  assign w_xfer   = r_tx_stb & ~io_bus.i_tx_busy;

  assign io_bus.o_busy    = w_busy;
  assign io_bus.o_tx_stb  = r_tx_stb;
  assign io_bus.o_tx_data = r_tx_data;

`ifdef HEX_WORD_TX_ZSUPPRESS_EN
  logic [CW-1:0] w_lz;
  logic          w_nz_seen;

  // Pre-align the word past its leading zeros so DIGIT starts on the first
  // significant nibble; the lowest nibble is never skipped.
  always_comb begin
    w_lz      = {CW{1'b0}};
    w_nz_seen = 1'b0;
    for (int k = NIB - 1; k >= 1; k--) begin
      if (!w_nz_seen && (io_bus.i_data[4*k +: 4] == 4'h0)) begin
        w_lz = w_lz + CW'(1'b1);
      end else begin
        w_nz_seen = 1'b1;
      end
    end
    if (io_bus.i_zsup) begin
      w_load     = io_bus.i_data << {w_lz, 2'b00};
      w_cnt_load = CNT_TOP - w_lz;
    end else begin
      w_load     = io_bus.i_data;
      w_cnt_load = CNT_TOP;
    end
  end
`else
  assign w_load     = io_bus.i_data;
  assign w_cnt_load = CNT_TOP;
`endif

  // Next frame state; everything except acceptance moves only on a transfer
  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_cnt_nx   = r_cnt;
    w_lower_nx = r_lower;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nx = FIRST_ST;
          w_shift_nx = w_load;
          w_cnt_nx   = w_cnt_load;
          w_lower_nx = io_bus.i_lower;
        end else begin
          w_state_nx = IDLE;
        end
      end
      PFX0: begin
        if (w_xfer) begin
          w_state_nx = PFX1;
        end else begin
          w_state_nx = PFX0;
        end
      end
      PFX1: begin
        if (w_xfer) begin
          w_state_nx = DIGIT;
        end else begin
          w_state_nx = PFX1;
        end
      end
      DIGIT: begin
        if (w_xfer) begin
          w_shift_nx = r_shift << 3'd4;
          if (r_cnt == {CW{1'b0}}) begin
            w_state_nx = TAIL_ST;
          end else begin
            w_cnt_nx = r_cnt - CW'(1'b1);
          end
        end else begin
          w_state_nx = DIGIT;
        end
      end
      EOL_CR: begin
        if (w_xfer) begin
          w_state_nx = EOL_LF;
        end else begin
          w_state_nx = EOL_CR;
        end
      end
      EOL_LF: begin
        if (w_xfer) begin
          w_state_nx = IDLE;
        end else begin
          w_state_nx = EOL_LF;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  hex_nibble_ascii u_nibble (
    .i_nib   (w_shift_nx[DW-1 -: 4]),
    .i_lower (w_lower_nx),
    .o_ascii (w_digit_nx)
  );

  // Byte to present in the coming state; IDLE keeps the last byte on the bus
  always_comb begin
    w_byte_nx = r_tx_data;
    case (w_state_nx)
      PFX0:    w_byte_nx = ASC_ZERO;
      PFX1:    w_byte_nx = ASC_X;
      DIGIT:   w_byte_nx = w_digit_nx;
      EOL_CR:  w_byte_nx = ASC_CR;
      EOL_LF:  w_byte_nx = ASC_LF;
      default: w_byte_nx = r_tx_data;
    endcase
  end

  // Frame registers; reset wins over a same-cycle request
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_shift   <= {DW{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_lower   <= 1'b0;
      r_tx_stb  <= 1'b0;
      r_tx_data <= ASC_ZERO;
    end else begin
      r_state   <= w_state_nx;
      r_shift   <= w_shift_nx;
      r_cnt     <= w_cnt_nx;
      r_lower   <= w_lower_nx;
      r_tx_stb  <= (w_state_nx != IDLE);
      r_tx_data <= w_byte_nx;
    end
  end

endmodule
